// File: rtl/audio_pkg.sv
// Shared audio-path definitions used by the codec transmit and receive blocks.
package audio_pkg;

  localparam int AUDIO_W     = 16;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_L,
    DELAY,
    SHIFT,
    PAD
  } tx_state_t;

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous codec clock into the clk domain and produces
// single-cycle rise/fall strobes on the synchronised level.
module edge_sync
  import audio_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              level;

  always_comb begin
    sync_d = STAGES'({sync_q, d});
    level  = sync_q[STAGES-1];
    prev_d = level;
    rise   = level & ~prev_q;
    fall   = ~level & prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/dac_send.sv
// I2S DAC transmitter: buffers one mono sample and serialises it MSB-first
// on both channels, timed by the oversampled codec bit and word clocks.
module dac_send
  import audio_pkg::*;
#(
  parameter int N = AUDIO_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sample_data,
  input  logic         valid,
  output logic         ready,
  input  logic         bclk,
  input  logic         daclrck,
  output logic         dacdat,
  output logic         underrun
);

  localparam int CW = $clog2(N + 1);

  logic bclk_fall, bclk_rise_unused;
  logic lr_rise, lr_fall, lr_edge;

  edge_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bclk),
    .rise  (bclk_rise_unused),
    .fall  (bclk_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_lr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (daclrck),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  tx_state_t     state_q, state_d;
  logic [N-1:0]  hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [N-1:0]  frame_q, frame_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dacdat_q, dacdat_d;
  logic          underrun_q, underrun_d;

  assign lr_edge = lr_fall | lr_rise;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    dacdat_d    = dacdat_q;
    underrun_d  = 1'b0;

    // The frame sees hold as it was before any same-cycle accept.
    if (lr_fall) begin
      if (hold_full_q) begin
        frame_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
    end

    if (valid && !hold_full_q) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end

    if (state_q == WAIT_L) begin
      dacdat_d = 1'b0;
      if (lr_fall) begin
        state_d = DELAY;
        sh_d    = frame_d;
        cnt_d   = '0;
      end
    end else if (lr_edge) begin
      // Any word-clock edge restarts the word; the coincident bclk fall is the boundary.
      state_d  = DELAY;
      sh_d     = frame_d;
      cnt_d    = '0;
      dacdat_d = 1'b0;
    end else if (bclk_fall) begin
      unique case (state_q)
        DELAY: begin
          dacdat_d = sh_q[N-1];
          sh_d     = {sh_q[N-2:0], 1'b0};
          cnt_d    = CW'(1);
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CW'(N)) begin
            dacdat_d = 1'b0;
            state_d  = PAD;
          end else begin
            dacdat_d = sh_q[N-1];
            sh_d     = {sh_q[N-2:0], 1'b0};
            cnt_d    = cnt_q + CW'(1);
          end
        end
        PAD:     dacdat_d = 1'b0;
        default: state_d = WAIT_L;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_L;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ready    = !hold_full_q;
  assign dacdat   = dacdat_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_send.sv
// Bench for dac_send: emulates the codec clocks, offers random and directed
// samples, and compares every serial slot against a frame-level model.
module tb_dac_send;
  import audio_pkg::*;

  localparam int N = AUDIO_W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic         bclk = 1'b1;
  logic         daclrck = 1'b1;
  logic [N-1:0] sample_data = '0;
  logic         ready, dacdat, underrun;

  always #5 clk = ~clk;

  dac_send #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_data (sample_data),
    .valid       (valid),
    .ready       (ready),
    .bclk        (bclk),
    .daclrck     (daclrck),
    .dacdat      (dacdat),
    .underrun    (underrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one-deep buffer, word per stereo frame, 3-cycle pin latency.
  logic [N-1:0] src_q[$];
  bit           m_full = 1'b0;
  logic [N-1:0] m_val = '0;
  int           m_acc = 0;
  logic [N-1:0] cur_word = '0;
  bit           active = 1'b0;
  int           lstart_due = -1;
  int           last_lstart = 0;
  int           last_acc_tick = 0;
  bit           rdy_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input int s);
    if (!active || s < 1 || s > N) return 1'b0;
    return cur_word[N-s];
  endfunction

  task automatic tick();
    bit exp_u;
    @(negedge clk);
    cyc++;
    exp_u = 1'b0;
    if (!reset && valid && rdy_seen) begin
      m_full        = 1'b1;
      m_val         = sample_data;
      m_acc         = cyc;
      last_acc_tick = cyc;
      void'(src_q.pop_front());
    end
    if (!reset && cyc == lstart_due) begin
      last_lstart = cyc;
      active      = 1'b1;
      if (m_full && m_acc < cyc) begin
        cur_word = m_val;
        m_full   = 1'b0;
      end else begin
        cur_word = '0;
        exp_u    = 1'b1;
      end
    end
    chk("underrun", underrun, exp_u);
    chk("ready", ready, !m_full);
    rdy_seen = ready;
    if (!reset && src_q.size() > 0) begin
      valid       = 1'b1;
      sample_data = src_q[0];
    end else begin
      valid       = 1'b0;
      sample_data = N'($urandom);
    end
  endtask

  // One stereo frame; bclk half-period is 6 clk cycles.
  task automatic frame(input int spc, input int off_slot = -1, input int off_h = 0,
                       input logic [N-1:0] off_val = '0, input int rst_slot = -1);
    for (int ch = 0; ch < 2; ch++) begin
      for (int s = 0; s < spc; s++) begin
        for (int h = 0; h < 12; h++) begin
          if (ch * spc + s == off_slot && h == off_h) src_q.push_back(off_val);
          tick();
          if (h == 0) begin
            bclk = 1'b0;
            if (s == 0) begin
              daclrck = ch[0];
              if (ch == 0) lstart_due = cyc + 3;
            end
          end
          if (h == 3 && ch == 0 && s == rst_slot) begin
            reset      = 1'b1;
            valid      = 1'b0;
            src_q.delete();
            m_full     = 1'b0;
            active     = 1'b0;
            lstart_due = -1;
            #1;
            chk("rst_mid_dacdat", dacdat, 0);
            chk("rst_mid_ready", ready, 1);
          end
          if (h == 5 && reset) reset = 1'b0;
          if (h == 6) begin
            chk("dacdat", dacdat, exp_bit(s));
            bclk = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    repeat (4) tick();
    chk("rst_dacdat", dacdat, 0);
    chk("rst_ready", ready, 1);
    chk("rst_underrun", underrun, 0);
    reset = 1'b0;

    // Basic frame with a known pattern, then random words offered mid-frame.
    src_q.push_back(16'hA5C3);
    repeat (6) tick();
    frame(32, 40, 0, N'($urandom));
    for (int i = 0; i < 3; i++) frame(32, 40, 0, N'($urandom));

    // Underrun frames, then recovery with 16'h8001.
    frame(32);
    frame(32);
    frame(32, 10, 0, 16'h8001);
    frame(32);

    // Backpressure: second word must wait for the left-frame start.
    src_q.push_back(16'h1111);
    src_q.push_back(16'h2222);
    repeat (3) tick();
    frame(32);
    chk("bp_accept_after_lstart", last_acc_tick - last_lstart, 1);
    frame(32);

    // Short word clock truncates the word, then a normal frame recovers.
    for (int i = 0; i < 3; i++) frame(8, 3, 0, N'($urandom));
    frame(32);

    // Reset mid-word; silence until the next left edge, then resume.
    frame(32, 40, 0, N'($urandom));
    frame(32, 40, 0, N'($urandom), 5);
    frame(32);

    // Sample offered exactly on the left-frame load cycle with hold empty.
    frame(32, 0, 2, N'($urandom));
    frame(32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_send.md
# dac_send

Single-clock I2S transmitter feeding the audio codec's DAC input; the output-side counterpart of `mic_load`. It accepts mono samples over a valid/ready handshake in the `adc_clk` domain, oversamples the codec-driven `AUD_BCLK` and `AUD_DACLRCK`, and serialises each sample MSB-first onto `AUD_DACDAT` in I2S format, sending the same sample on the left and right channels. It sits between the on-chip audio source (tone or playback logic) and the codec pins, alongside `mic_load`, under `mic_top_level`'s codec setup.

## Interface
- `N`, 16, sample width in bits (two's complement)
- `clk`  in  1  system clock (`adc_clk`, 18.432 MHz); the only clock
- `reset`  in  1  asynchronous, active-high reset
- `sample_data`  in  N  sample to transmit
- `valid`  in  1  `sample_data` is valid this cycle
- `ready`  out  1  holding register empty; transfer occurs when `valid && ready` on a `clk` rising edge
- `bclk`  in  1  codec bit clock (`AUD_BCLK`), asynchronous to `clk`
- `daclrck`  in  1  codec DAC word clock (`AUD_DACLRCK`): low = left, high = right
- `dacdat`  out  1  serial data to `AUD_DACDAT`, registered
- `underrun`  out  1  one-cycle pulse: left frame started with no sample held

## Operation
- `bclk` and `daclrck` each pass through a 2-flop synchroniser plus an edge register; a falling/rising edge is a one-cycle strobe on the synchronised signal.
- Holding register `hold` with flag `hold_full`; `ready = !hold_full`. Accept: `hold <= sample_data`, `hold_full <= 1`.
- Frame register `frame`: loaded at each left-frame start (synchronised `daclrck` falling edge). If `hold_full`, then `frame <= hold` and `hold_full <= 0`. Otherwise `frame <= 0` and `underrun` pulses. A right-frame start (rising edge) retransmits `frame` unchanged.
- Simultaneous accept and left-frame start with `hold_full = 0`: the frame sees the empty hold, so `underrun` pulses and `frame <= 0`. The accepted sample stays in `hold` for the next left frame.
- Shift register `sh` (N bits), bit counter `cnt` ($clog2(N+1) bits). States:
  - WAIT_L: after reset. `dacdat = 0`; ignores everything until a left-frame start, then goes to DELAY (loading `frame`).
  - DELAY: entered on any `daclrck` edge; `sh <= frame`, `cnt <= 0`. A `bclk` falling strobe in the same cycle as the `daclrck` strobe is the boundary edge and is ignored. The next `bclk` falling strobe drives `dacdat <= sh[N-1]` and moves to SHIFT.
  - SHIFT: each `bclk` falling strobe shifts the next bit out, MSB-first. After bit 0 has been driven, the following falling strobe drives 0 and moves to PAD.
  - PAD: `dacdat = 0` until the next `daclrck` edge, then goes to DELAY.
- A `daclrck` edge in any state other than WAIT_L (including mid-SHIFT) aborts the current word and enters DELAY for the new channel. A short word clock truncates the word LSB-side; it is never a lockup.
- `valid` is ignored while `ready = 0`; `sample_data` may change freely then.

## Timing
- Reset values: `dacdat = 0`, `ready = 1`, `underrun = 0`, state WAIT_L, `hold`/`frame`/`sh` = 0, `cnt` = 0.
- Reset asserted mid-frame forces `dacdat = 0` immediately and discards any held sample. After release, output resumes only at the next left-frame start, never mid-right-frame.
- Pin-edge-to-`dacdat` latency: 3 `clk` cycles (2 sync + 1 output register).
- The codec samples `dacdat` on `bclk` rising edges. Correct operation therefore requires a `bclk` half-period of at least 4 `clk` periods.
- `ready` rises one cycle after the left-frame start that empties `hold`.
- Per channel: 1 delay slot, N data slots, zero padding for the remaining slots.

## Structure
- Shared package `audio_pkg`:
  - `tx_state_t` enum (WAIT_L, DELAY, SHIFT, PAD)
  - `SYNC_STAGES = 2`
  - default width `AUDIO_W = 16`, shared with `mic_load`
- Sub-module `edge_sync`: synchroniser plus rise/fall strobes, parameterised by `SYNC_STAGES`, async active-high reset. Instantiated twice (`bclk`, `daclrck`).
- Top level may wrap the port pair (`sample_data`/`valid`) in `dstream`, with `ready` added alongside.

## Test plan
- Basic frame: send `16'hA5C3` before the first left edge; `bclk` = `clk`/12, 32 slots per channel. Expect `dacdat` on slots 1–16 of both left and right = 1010_0101_1100_0011, slot 0 and slots 17–31 = 0, no `underrun`.
- Underrun: no sample offered. Expect `underrun` high for exactly 1 cycle at each left-frame start and all-zero data; then offer `16'h8001` and expect it at the next left frame.
- Backpressure: hold `valid` high with `16'h1111` then `16'h2222`. Expect `ready` = 0 after the first accept, the second accepted only after the left-frame start, and the words transmitted in order.
- Short word clock: 8 slots per channel with N = 16. Expect the MSB-first 7 bits of the word, then a clean restart at each `daclrck` edge with no stuck state.
- Reset mid-SHIFT: assert `reset` during the left word. Expect `dacdat` = 0 at once and `ready` = 1; after release, stay silent through the right frame and resume at the next left edge.
- Simultaneous event: `valid` asserted on the exact cycle of the left-frame strobe with `hold` empty. Expect an `underrun` pulse, zeros in this frame, and the sample transmitted in the following frame.
